// File: rtl/johnson_pkg.sv
// rtl/johnson_pkg.sv - shared encodings and legal code table for the Johnson code monitor
package johnson_pkg;

    localparam int CODE_W = 4;
    localparam int NUM_PH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_LOCK  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    // Position in this table is the phase index reported downstream.
    localparam logic [CODE_W-1:0] JC_TABLE [NUM_PH] = '{
        4'b0000, 4'b1000, 4'b1100, 4'b1110,
        4'b1111, 4'b0111, 4'b0011, 4'b0001
    };

endpackage

// File: rtl/johnson_decode.sv
// rtl/johnson_decode.sv - combinational map from a Johnson code to {legal, phase index}
module johnson_decode
    import johnson_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic              legal,
    output logic [2:0]        idx
);

    always_comb begin
        legal = 1'b0;
        idx   = 3'd0;
        for (int i = 0; i < NUM_PH; i++) begin
            if (code == JC_TABLE[i]) begin
                legal = 1'b1;
                idx   = 3'(i);
            end
        end
    end

endmodule

// File: rtl/johnson_monitor.sv
// rtl/johnson_monitor.sv - tracks a 4-bit Johnson counter, flags bad steps, counts revolutions and errors
module johnson_monitor
    import johnson_pkg::*;
#(
    parameter int REV_W = 8,
    parameter int ERR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [CODE_W-1:0] jc_in,
    input  logic              clr_cnt,
    output logic [7:0]        phase,
    output logic [2:0]        phase_idx,
    output logic              valid,
    output logic              locked,
    output logic              err,
    output logic [REV_W-1:0]  rev_count,
    output logic              rev_wrap,
    output logic [ERR_W-1:0]  err_count
);

    state_t     state, state_nxt;
    logic       dec_legal;
    logic [2:0] dec_idx;
    logic [2:0] idx_inc;
    logic       is_adv, is_hold;
    logic       err_evt, rev_evt;

    johnson_decode u_decode (
        .code  (jc_in),
        .legal (dec_legal),
        .idx   (dec_idx)
    );

    // phase_idx always holds the last legal index, so it is the step reference.
    assign idx_inc = phase_idx + 3'd1;
    assign is_adv  = (dec_idx == idx_inc);
    assign is_hold = (dec_idx == phase_idx);
    assign locked  = (state == ST_LOCK);

    always_comb begin
        state_nxt = state;
        err_evt   = 1'b0;
        rev_evt   = 1'b0;
        if (en) begin
            case (state)
                ST_IDLE: begin
                    if (dec_legal) begin
                        state_nxt = ST_SYNC;
                    end else begin
                        state_nxt = ST_FAULT;
                        err_evt   = 1'b1;
                    end
                end
                ST_SYNC: begin
                    if (dec_legal && is_adv) begin
                        state_nxt = ST_LOCK;
                    end else if (!(dec_legal && is_hold)) begin
                        state_nxt = ST_FAULT;
                        err_evt   = 1'b1;
                    end
                end
                ST_LOCK: begin
                    if (dec_legal && (is_adv || is_hold)) begin
                        rev_evt = is_adv && (phase_idx == 3'd7);
                    end else begin
                        state_nxt = ST_FAULT;
                        err_evt   = 1'b1;
                    end
                end
                ST_FAULT: begin
                    if (dec_legal) begin
                        state_nxt = ST_SYNC;
                    end else begin
                        err_evt = 1'b1;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            phase     <= 8'd0;
            phase_idx <= 3'd0;
            valid     <= 1'b0;
            err       <= 1'b0;
            rev_wrap  <= 1'b0;
            rev_count <= '0;
            err_count <= '0;
        end else begin
            state    <= state_nxt;
            err      <= err_evt;
            rev_wrap <= rev_evt && (&rev_count);
            if (en) begin
                valid <= dec_legal;
                if (dec_legal) begin
                    phase     <= 8'b1 << dec_idx;
                    phase_idx <= dec_idx;
                end
            end
            // Clearing wins over any increment in the same cycle; pulses still fire.
            if (clr_cnt) begin
                rev_count <= '0;
                err_count <= '0;
            end else begin
                if (rev_evt) begin
                    rev_count <= rev_count + 1'b1;
                end
                if (err_evt && !(&err_count)) begin
                    err_count <= err_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/johnson_monitor.md
JOHNSON_MONITOR -- requirements
Module: johnson_monitor

Interface
REQ-001 Parameter REV_W, default 8: width of the revolution counter.
REQ-002 Parameter ERR_W, default 4: width of the saturating error counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-low; sampled on the clk rising edge.
REQ-005 en  input  1  sample enable; jc_in is evaluated only on edges where en=1.
REQ-006 jc_in  input  4  Johnson code from the upstream 4-bit Johnson counter.
REQ-007 clr_cnt  input  1  synchronous clear of rev_count and err_count.
REQ-008 phase  output  8  registered one-hot decode of the last legal code.
REQ-009 phase_idx  output  3  registered binary index of the last legal code.
REQ-010 valid  output  1  high while phase/phase_idx reflect a legal sampled code.
REQ-011 locked  output  1  high in state LOCK.
REQ-012 err  output  1  one-cycle pulse per detected error event.
REQ-013 rev_count  output  REV_W  count of completed revolutions (index 7 -> 0), wrapping.
REQ-014 rev_wrap  output  1  one-cycle pulse when rev_count wraps from all-ones to 0.
REQ-015 err_count  output  ERR_W  error-event count, saturating at all-ones.

Function
REQ-016 The legal code order SHALL be idx0..7 = 0000,1000,1100,1110,1111,0111,0011,0001; the other 8 codes are illegal.
REQ-017 Outputs SHALL be registered; a code sampled at edge N is reflected on all outputs after edge N (latency 1 cycle).
REQ-018 When en=0, state, phase, phase_idx, valid and counters SHALL hold; err and rev_wrap SHALL be 0.
REQ-019 A legal code SHALL update phase (bit idx set), phase_idx and set valid=1; an illegal code SHALL hold phase/phase_idx and clear valid.
REQ-020 A step SHALL be "good" when the new index equals the previous index (hold) or previous+1 mod 8 (advance).
REQ-021 FSM states: IDLE, SYNC, LOCK, FAULT.
REQ-022 IDLE: legal code -> SYNC; illegal -> FAULT with error event.
REQ-023 SYNC: good advance -> LOCK; hold -> stay; bad legal step or illegal code -> FAULT with error event.
REQ-024 LOCK: good step -> stay; bad legal step or illegal code -> FAULT with error event.
REQ-025 FAULT: legal code -> SYNC without error event; illegal -> stay, error event per sampled cycle.
REQ-026 rev_count SHALL increment by 1 only in LOCK on an advance from idx7 to idx0; wrap to 0 SHALL pulse rev_wrap.
REQ-027 Each error event SHALL pulse err and increment err_count unless err_count is all-ones (saturate).
REQ-028 clr_cnt=1 SHALL zero rev_count and err_count, taking priority over any same-cycle increment; FSM, phase and err/rev_wrap pulses are unaffected.

Reset
REQ-029 rst=0 at an edge SHALL force state IDLE, phase=0, phase_idx=0, valid=0, locked=0, err=0, rev_wrap=0, rev_count=0, err_count=0, overriding en and clr_cnt.
REQ-030 Reset asserted mid-operation SHALL abandon the current lock; the first sample after release is treated as from IDLE.

Structure
REQ-031 A shared package johnson_pkg SHALL hold the FSM state encoding, the 8-entry legal code table and the code width constant (4).
REQ-032 One combinational sub-module johnson_decode SHALL map jc_in to {legal, idx[2:0]}; johnson_monitor instantiates it once.

Verification
REQ-033 Reset, then en=1 with jc_in cycling 0000..0001 twice from idx0 -> locked=1 one cycle after second sample, rev_count=2 after second wrap to 0000.
REQ-034 In LOCK inject jc_in=1010 for one cycle -> err pulses once, err_count=1, valid=0, state FAULT; next 1100 -> SYNC, valid=1, phase=8'b0000_0100.
REQ-035 In LOCK jump idx2->idx5 (1100->0111) -> err pulse, err_count+1, FAULT then SYNC; phase_idx=5.
REQ-036 Hold 20 illegal samples with ERR_W=4 -> err_count saturates at 15, err pulses every cycle.
REQ-037 REV_W=2, run 4 full revolutions -> rev_count 3->0 with rev_wrap single pulse; clr_cnt with simultaneous error -> both counters 0.
REQ-038 Drive rst=0 mid-LOCK with en=0 and clr_cnt=1 -> all outputs 0, state IDLE on next cycle.
